// File: rtl/uart_transmitter_axis_fifo.sv
// UART transmitter fed by an AXI4-Stream word input through a transmit FIFO.
// Queued frames leave back to back; word width, parity and stop bits are parameters.
module uart_transmitter_axis_fifo #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int WORD_WIDTH      = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WORD_WIDTH-1:0]           din_axis_tdata,
  input  logic                            din_axis_tvalid,
  output logic                            din_axis_tready,
  output logic                            dout,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CYCLES_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA   = 4'(WORD_WIDTH - 1);
  localparam logic [3:0]    LAST_STOP   = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);

  if (WORD_WIDTH < 5 || WORD_WIDTH > 9) begin : g_bad_word_width
    $error("WORD_WIDTH must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  if (CYCLES_PER_BIT < 2) begin : g_bad_baud
    $error("CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_n;
  logic                  push, pop, full;
  logic [WORD_WIDTH-1:0] head;

  state_t                state, state_n;
  logic [BW-1:0]         baud_cnt, baud_cnt_n;
  logic [3:0]            bit_cnt, bit_cnt_n;
  logic [WORD_WIDTH-1:0] shreg, shreg_n;
  logic                  par_bit, par_bit_n;
  logic                  dout_n;
  logic                  bit_end;

  // tready must not see tvalid: it is purely occupancy and reset.
  assign full            = (fifo_count == FULL_COUNT);
  assign din_axis_tready = !full && rst_n;
  assign push            = din_axis_tvalid && din_axis_tready;
  assign head            = mem[rd_ptr];
  assign bit_end         = (baud_cnt == '0);

  function automatic logic parity_of(input logic [WORD_WIDTH-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_n    = state;
    baud_cnt_n = bit_end ? BAUD_RELOAD : baud_cnt - BW'(1);
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    dout_n     = dout;
    pop        = 1'b0;

    case (state)
      S_IDLE: begin
        baud_cnt_n = BAUD_RELOAD;
        pop        = (fifo_count != '0);
      end
      S_START: begin
        if (bit_end) begin
          state_n   = S_DATA;
          bit_cnt_n = '0;
          dout_n    = shreg[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_n = '0;
            if (PARITY != 0) begin
              state_n = S_PARITY;
              dout_n  = par_bit;
            end else begin
              state_n = S_STOP;
              dout_n  = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
            shreg_n   = shreg >> 1;
            dout_n    = shreg[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          dout_n  = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_n = '0;
            state_n   = S_IDLE;
            dout_n    = 1'b1;
            pop       = (fifo_count != '0);
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A pop always launches a start bit, whether from idle or straight after a stop bit.
    if (pop) begin
      state_n    = S_START;
      baud_cnt_n = BAUD_RELOAD;
      shreg_n    = head;
      par_bit_n  = parity_of(head);
      dout_n     = 1'b0;
    end
  end

  always_comb begin
    count_n = fifo_count;
    if (push && !pop)      count_n = fifo_count + CW'(1);
    else if (pop && !push) count_n = fifo_count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= BAUD_RELOAD;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      dout       <= 1'b1;
      busy       <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      dout       <= dout_n;
      busy       <= (state_n != S_IDLE) || (count_n != '0);
      fifo_count <= count_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // NOTE: the storage array has no reset; flushing the pointers and count is enough to empty it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din_axis_tdata;
  end

endmodule

// File: tb/tb_uart_transmitter_axis_fifo.sv
// Directed bench for uart_transmitter_axis_fifo: four instances cover the default,
// even/odd parity and 7-bit/two-stop-bit configurations at 10 clocks per bit.
module tb_uart_transmitter_axis_fifo;

  localparam int CLK_HZ = 1_050_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = 10;          // 1_050_000 / 100_000 truncated
  localparam int FRAME8 = 10 * CPB;    // start + 8 data + 1 stop

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] tdata0, tdata1, tdata2;
  logic [6:0] tdata3;
  logic       tvalid0, tvalid1, tvalid2, tvalid3;
  logic       tready0, tready1, tready2, tready3;
  logic       dout0, dout1, dout2, dout3;
  logic       busy0, busy1, busy2, busy3;
  logic [4:0] count0, count1, count2, count3;
  logic [3:0] douts;
  assign douts = {dout3, dout2, dout1, dout0};

  int compared   = 0;
  int mismatched = 0;

  uart_transmitter_axis_fifo #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .WORD_WIDTH(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .din_axis_tdata(tdata0), .din_axis_tvalid(tvalid0),
    .din_axis_tready(tready0), .dout(dout0), .busy(busy0), .fifo_count(count0));

  uart_transmitter_axis_fifo #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .WORD_WIDTH(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_even (
    .clk(clk), .rst_n(rst_n), .din_axis_tdata(tdata1), .din_axis_tvalid(tvalid1),
    .din_axis_tready(tready1), .dout(dout1), .busy(busy1), .fifo_count(count1));

  uart_transmitter_axis_fifo #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .WORD_WIDTH(8),
    .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_odd (
    .clk(clk), .rst_n(rst_n), .din_axis_tdata(tdata2), .din_axis_tvalid(tvalid2),
    .din_axis_tready(tready2), .dout(dout2), .busy(busy2), .fifo_count(count2));

  uart_transmitter_axis_fifo #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .WORD_WIDTH(7),
    .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_w7s2 (
    .clk(clk), .rst_n(rst_n), .din_axis_tdata(tdata3), .din_axis_tvalid(tvalid3),
    .din_axis_tready(tready3), .dout(dout3), .busy(busy3), .fifo_count(count3));

  // Called at the negedge inside the first cycle of a start bit; checks the first and
  // last cycle of every bit and returns at the negedge just after the frame.
  task automatic check_frame(input int sel, input logic [15:0] bits, input int nbits,
                             input string name);
    for (int k = 0; k < nbits; k++) begin
      logic first_s, last_s;
      first_s = 1'bx;
      last_s  = 1'bx;
      for (int c = 0; c < CPB; c++) begin
        if (c == 0)       first_s = douts[sel];
        if (c == CPB - 1) last_s  = douts[sel];
        @(negedge clk);
      end
      compared++;
      if (first_s !== bits[k] || last_s !== bits[k]) begin
        mismatched++;
        $display("FAIL %s bit %0d: got %b..%b, expected %b", name, k, first_s, last_s, bits[k]);
      end
    end
  endtask

  task automatic wait_start(input int sel, input int limit, input string name);
    int n;
    n = 0;
    while (douts[sel] !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (douts[sel] !== 1'b0) begin
      mismatched++;
      $display("FAIL %s: no start bit within %0d cycles", name, limit);
    end
  endtask

  task automatic check_idle(input int sel, input logic busy_v, input string name);
    compared++;
    if (douts[sel] !== 1'b1 || busy_v !== 1'b0) begin
      mismatched++;
      $display("FAIL %s: dout=%b busy=%b, expected dout=1 busy=0", name, douts[sel], busy_v);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tvalid0 = 1'b0; tvalid1 = 1'b0; tvalid2 = 1'b0; tvalid3 = 1'b0;
    tdata0 = '0; tdata1 = '0; tdata2 = '0; tdata3 = '0;
    repeat (3) @(negedge clk);
    compared++;
    if (dout0 !== 1'b1 || busy0 !== 1'b0 || count0 !== 5'd0) begin
      mismatched++;
      $display("FAIL reset_state: dout=%b busy=%b count=%0d, expected 1/0/0", dout0, busy0, count0);
    end
    compared++;
    if ({tready0, tready1, tready2, tready3} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_tready: got %b, expected 0000",
               {tready0, tready1, tready2, tready3});
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if ({tready0, tready1, tready2, tready3} !== 4'b1111) begin
      mismatched++;
      $display("FAIL release_tready: got %b, expected 1111",
               {tready0, tready1, tready2, tready3});
    end
    @(negedge clk);
  endtask

  task automatic test_single;
    tvalid0 = 1'b1; tdata0 = 8'hA5;
    @(negedge clk);
    tvalid0 = 1'b0;
    compared++;
    if (count0 !== 5'd1 || busy0 !== 1'b1 || dout0 !== 1'b1) begin
      mismatched++;
      $display("FAIL single_after_push: count=%0d busy=%b dout=%b, expected 1/1/1",
               count0, busy0, dout0);
    end
    @(negedge clk);
    compared++;
    if (dout0 !== 1'b0 || count0 !== 5'd0) begin
      mismatched++;
      $display("FAIL single_pop_latency: dout=%b count=%0d, expected 0/0", dout0, count0);
    end
    check_frame(0, {1'b1, 8'hA5, 1'b0}, 10, "single_a5");
    check_idle(0, busy0, "single_end");
  endtask

  task automatic test_burst;
    int   i, guard, bad;
    logic acc, saw_full;
    i = 0; guard = 0; bad = 0; saw_full = 1'b0;
    fork
      begin
        while (i < 20 && guard < 5000) begin
          tvalid0 = 1'b1;
          tdata0  = i[7:0];
          acc     = tready0;
          if ((count0 == 5'd16) !== (tready0 === 1'b0)) bad++;
          if (count0 == 5'd16) saw_full = 1'b1;
          @(negedge clk);
          if (acc) i++;
          guard++;
        end
        tvalid0 = 1'b0;
      end
      begin
        wait_start(0, 10, "burst_first_start");
        for (int k = 0; k < 20; k++) check_frame(0, {1'b1, k[7:0], 1'b0}, 10, "burst_frame");
      end
    join
    check_idle(0, busy0, "burst_end");
    compared++;
    if (bad != 0 || saw_full !== 1'b1) begin
      mismatched++;
      $display("FAIL burst_tready: %0d cycles with tready inconsistent with count==16, full seen=%b, expected 0 and 1",
               bad, saw_full);
    end
  endtask

  task automatic test_full;
    int bad, n;
    bad = 0;
    fork
      begin
        for (int w = 0; w < 17; w++) begin
          tvalid0 = 1'b1;
          tdata0  = 8'h40 + 8'(w);
          @(negedge clk);
        end
        compared++;
        if (count0 !== 5'd16 || tready0 !== 1'b0) begin
          mismatched++;
          $display("FAIL full_reached: count=%0d tready=%b, expected 16/0", count0, tready0);
        end
        tdata0 = 8'h51;
        n = 0;
        while (tready0 !== 1'b1 && n < 300) begin
          if (count0 !== 5'd16) bad++;
          @(negedge clk);
          n++;
        end
        tvalid0 = 1'b0;
        compared++;
        if (count0 !== 5'd15 || tready0 !== 1'b1) begin
          mismatched++;
          $display("FAIL full_pop_edge: count=%0d tready=%b, expected 15/1", count0, tready0);
        end
        repeat (FRAME8 - 1) @(negedge clk);
        compared++;
        if (count0 !== 5'd15) begin
          mismatched++;
          $display("FAIL pre_simul_count: got %0d, expected 15", count0);
        end
        tvalid0 = 1'b1;
        tdata0  = 8'h51;
        @(negedge clk);
        tvalid0 = 1'b0;
        compared++;
        if (count0 !== 5'd15) begin
          mismatched++;
          $display("FAIL simul_push_pop_count: got %0d, expected 15", count0);
        end
      end
      begin
        logic [7:0] w;
        wait_start(0, 10, "full_first_start");
        for (int k = 0; k < 18; k++) begin
          w = 8'h40 + 8'(k);
          check_frame(0, {1'b1, w, 1'b0}, 10, "full_frame");
        end
      end
    join
    check_idle(0, busy0, "full_end");
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL full_hold: %0d cycles with count!=16 while tready=0, expected 0", bad);
    end
  endtask

  task automatic test_parity;
    tvalid1 = 1'b1; tdata1 = 8'h07;
    @(negedge clk);
    tvalid1 = 1'b0;
    wait_start(1, 5, "even_start");
    check_frame(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11, "even_parity");
    check_idle(1, busy1, "even_end");
    tvalid2 = 1'b1; tdata2 = 8'h07;
    @(negedge clk);
    tvalid2 = 1'b0;
    wait_start(2, 5, "odd_start");
    check_frame(2, {1'b1, 1'b0, 8'h07, 1'b0}, 11, "odd_parity");
    check_idle(2, busy2, "odd_end");
  endtask

  task automatic test_stop_bits;
    tvalid3 = 1'b1; tdata3 = 7'h55;
    @(negedge clk);
    tvalid3 = 1'b0;
    wait_start(3, 5, "w7s2_start");
    check_frame(3, {2'b11, 7'h55, 1'b0}, 10, "w7s2_frame");
    check_idle(3, busy3, "w7s2_end");
  endtask

  task automatic test_reset_mid;
    int bad;
    bad = 0;
    tvalid0 = 1'b1; tdata0 = 8'h00;
    repeat (6) @(negedge clk);
    tvalid0 = 1'b0;
    compared++;
    if (count0 !== 5'd5) begin
      mismatched++;
      $display("FAIL mid_queued: count=%0d, expected 5", count0);
    end
    // Frame started at push edge 2; data bit 3 covers edges 42..52.
    repeat (39) @(negedge clk);
    compared++;
    if (dout0 !== 1'b0 || busy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_in_bit3: dout=%b busy=%b, expected 0/1", dout0, busy0);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (tready0 !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_tready: got %b, expected 0", tready0);
    end
    @(negedge clk);
    compared++;
    if (dout0 !== 1'b1 || count0 !== 5'd0 || busy0 !== 1'b0 || tready0 !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_after_reset: dout=%b count=%0d busy=%b tready=%b, expected 1/0/0/0",
               dout0, count0, busy0, tready0);
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (tready0 !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_release_tready: got %b, expected 1", tready0);
    end
    for (int c = 0; c < 3 * FRAME8; c++) begin
      @(negedge clk);
      if (dout0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL mid_quiet: %0d cycles active after reset, expected 0", bad);
    end
    tvalid0 = 1'b1; tdata0 = 8'h3C;
    @(negedge clk);
    tvalid0 = 1'b0;
    wait_start(0, 5, "mid_new_start");
    check_frame(0, {1'b1, 8'h3C, 1'b0}, 10, "mid_new_frame");
    check_idle(0, busy0, "mid_new_end");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_parity();
    test_stop_bits();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_transmitter_axis_fifo.md
# uart_transmitter_axis_fifo

Parametrised UART transmitter with an AXI4-Stream word input, an internal transmit FIFO, and configurable word width, parity and stop bits. It is the next generation of the single-word AXI-Stream transmitter. The FIFO lets upstream logic push a burst without waiting for each frame to finish, and queued frames go out back to back on one serial line. It sits between an AXI-Stream producer and the `dout` pin.

## Interface
- `CLOCK_FREQUENCY`, 100_000_000: clk frequency in Hz.
- `BAUD_RATE`, 115200: line rate. `CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE`, truncated.
- `WORD_WIDTH`, 8: data bits per frame. Legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: entries. Power of two, at least 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `din_axis_tdata`  in  WORD_WIDTH  word to send.
- `din_axis_tvalid`  in  1  producer has a word.
- `din_axis_tready`  out  1  FIFO can accept a word.
- `dout`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress or FIFO non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  words queued, not counting the frame being sent.

## Operation
- Reset (rst_n low at a rising edge): dout=1, busy=0, fifo_count=0, state IDLE, FIFO flushed. din_axis_tready=0 while rst_n is low.
- Push: tvalid && tready at a rising edge writes tdata into the FIFO.
- tready = !full && rst_n. tready is low exactly when fifo_count == FIFO_DEPTH.
- States and transitions:
  - IDLE: pops the FIFO when fifo_count > 0 and goes to START.
  - START: drives 0 for one bit.
  - DATA: sends WORD_WIDTH bits, LSB first.
  - PARITY: present only if PARITY != 0.
    - Odd: bit = ~^data.
    - Even: bit = ^data.
  - STOP: drives 1 for STOP_BITS bits.
- End of last stop bit: if the FIFO is non-empty, pop and enter START directly, with no idle cycle. Otherwise go to IDLE.
- Frame length is (1 + WORD_WIDTH + (PARITY!=0) + STOP_BITS) × CYCLES_PER_BIT cycles.
- Push and pop at the same edge: fifo_count is unchanged and data order is preserved.
- Full FIFO with a pop at edge N: tready rises after edge N. A push attempted at edge N is not accepted.
- Reset mid-frame: the frame is aborted, dout=1 from the next edge, and queued words are discarded.
- Illegal parameters cause an elaboration-time `$error`:
  - WORD_WIDTH outside 5..9;
  - PARITY > 2;
  - STOP_BITS not 1 or 2;
  - FIFO_DEPTH not a power of two;
  - CYCLES_PER_BIT < 2.

## Timing
- dout, busy and fifo_count are registered.
- Latency: a word pushed at edge N into an empty FIFO while IDLE is popped at edge N+1. dout goes 0 after edge N+1. fifo_count reads 1 for the cycle between edges N and N+1.
- Each bit is held for exactly CYCLES_PER_BIT cycles. The bit counter and baud counter reload at each bit boundary, with no cumulative drift.
- busy rises after the first push edge. It falls after the edge that ends the last stop bit, provided the FIFO is empty.
- tready depends combinationally only on internal full and rst_n. It has no path from tvalid.

## Test plan
- **Single frame, defaults** (CYCLES_PER_BIT=868): push 8'hA5.
  - Required: one cycle of dout=1, then bits 0,1,0,1,0,0,1,0,1,1, each held 868 cycles.
  - Then dout=1 and busy=0.
- **Burst**: hold tvalid with 20 words 0x00..0x13.
  - tready drops when fifo_count=16.
  - All 20 frames go out in order with no idle cycles between stop and start.
  - Total line time is 20×10×868 cycles.
- **Parity**, WORD_WIDTH=8: send 8'h07.
  - PARITY=2: parity bit 1.
  - PARITY=1: parity bit 0.
  - Frame is 11 bits.
- **Stop bits**, WORD_WIDTH=7, STOP_BITS=2, PARITY=0: send 7'h55.
  - Required: 0, 1,0,1,0,1,0,1, 1,1 — 10 bits.
- **Full/simultaneous**: fill the FIFO to 16 during a frame.
  - Required: tready=0.
  - At the pop edge, fifo_count becomes 15 and tready=1 in the next cycle.
  - A push and pop on the same edge leaves the count unchanged.
- **Reset mid-frame**: drive rst_n=0 during data bit 3 with 5 words queued.
  - Required: dout=1, fifo_count=0 and tready=0 after the next edge.
  - tready=1 in the first cycle with rst_n=1.
  - No frame appears until a new push.
